// File: rtl/mux_bus_rr_arbiter_if.sv
// rtl/mux_bus_rr_arbiter_if.sv - requester/consumer signal bundle for mux_bus_rr_arbiter
// Ports (slave = arbiter side):
//   req, last, d   requester valid, end-of-packet flag and packed data (requester i at d[i*C_WIDTH +: C_WIDTH])
//   ack            one-hot beat accept back to the requesters
//   s              current grant index
//   q, q_valid, q_last, q_ready   registered output beat and downstream handshake
//   busy           arbiter is inside a granted packet
interface mux_bus_rr_arbiter_if #(
  parameter int C_INPUTS    = 4,
  parameter int C_WIDTH     = 8,
  parameter int C_SEL_WIDTH = 2
);
  logic [C_INPUTS-1:0]         req;
  logic [C_INPUTS-1:0]         last;
  logic [C_INPUTS*C_WIDTH-1:0] d;
  logic [C_INPUTS-1:0]         ack;
  logic [C_SEL_WIDTH-1:0]      s;
  logic [C_WIDTH-1:0]          q;
  logic                        q_valid;
  logic                        q_last;
  logic                        q_ready;
  logic                        busy;

  modport master (
    output req, last, d, q_ready,
    input  ack, s, q, q_valid, q_last, busy
  );

  modport slave (
    input  req, last, d, q_ready,
    output ack, s, q, q_valid, q_last, busy
  );
endinterface

// File: rtl/mux_bus_rr_arbiter.sv
// rtl/mux_bus_rr_arbiter.sv - round-robin packet arbiter driving a registered shared bus mux
// Ports:
//   clk    rising-edge clock
//   sclr   synchronous active-high reset, overrides ce
//   ce     clock enable (only used when C_HAS_CE != 0)
//   bus    mux_bus_rr_arbiter_if.slave: req/last/d in, ack/s out, q/q_valid/q_last out, q_ready in, busy out
module mux_bus_rr_arbiter #(
  parameter int C_INPUTS    = 4,
  parameter int C_WIDTH     = 8,
  parameter int C_SEL_WIDTH = 2,
  parameter int C_HAS_CE    = 0
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 ce,
  mux_bus_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_next;
  logic [C_SEL_WIDTH-1:0]  ptr;
  logic [C_SEL_WIDTH-1:0]  sel;
  logic [C_SEL_WIDTH-1:0]  winner;
  logic                    found;
  logic                    any_req;
  logic                    ce_int;
  logic                    xfer;
  logic                    sel_req;
  logic                    sel_last;
  logic [C_WIDTH-1:0]      sel_data;
  logic [C_INPUTS-1:0]     ack_vec;
  logic [C_WIDTH-1:0]      q_reg;
  logic                    q_valid_reg;
  logic                    q_last_reg;

  assign ce_int   = (C_HAS_CE != 0) ? ce : 1'b1;
  assign any_req  = |bus.req;
  assign sel_req  = bus.req[sel];
  assign sel_last = bus.last[sel];
  assign sel_data = bus.d[int'(sel)*C_WIDTH +: C_WIDTH];

  // Search starts just after the previous packet owner, so that owner
  // becomes lowest priority for this arbitration.
  always_comb begin
    winner = sel;
    found  = 1'b0;
    for (int k = 1; k <= C_INPUTS; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % C_INPUTS]) begin
        winner = C_SEL_WIDTH'((int'(ptr) + k) % C_INPUTS);
        found  = 1'b1;
      end
    end
  end

  // A beat moves only when the output register is empty or draining this
  // cycle; sclr suppresses the accept so a reset cycle never ACKs.
  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = GRANT;
      end
      GRANT: begin
        xfer = sel_req & (~q_valid_reg | bus.q_ready) & ce_int & ~sclr;
        if (xfer && sel_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack_vec = '0;
    if (xfer) ack_vec[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state       <= IDLE;
      ptr         <= C_SEL_WIDTH'(C_INPUTS - 1);
      sel         <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      q_last_reg  <= 1'b0;
    end else if (ce_int) begin
      state <= state_next;
      if (state == IDLE && any_req) sel <= winner;
      if (xfer) begin
        q_reg       <= sel_data;
        q_valid_reg <= 1'b1;
        q_last_reg  <= sel_last;
        if (sel_last) ptr <= sel;
      end else if (bus.q_ready) begin
        // Draining works in either state so the final beat leaves during IDLE.
        q_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.ack     = ack_vec;
  assign bus.s       = sel;
  assign bus.q       = q_reg;
  assign bus.q_valid = q_valid_reg;
  assign bus.q_last  = q_last_reg;
  assign bus.busy    = (state == GRANT);

endmodule

// File: tb/tb_mux_bus_rr_arbiter.sv
// tb/tb_mux_bus_rr_arbiter.sv - self-checking bench for mux_bus_rr_arbiter
module tb_mux_bus_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic sclr;
  logic ce;
  int   n_cmp = 0;
  int   n_mis = 0;

  mux_bus_rr_arbiter_if #(.C_INPUTS(N), .C_WIDTH(W), .C_SEL_WIDTH(SW)) bus ();

  mux_bus_rr_arbiter #(.C_INPUTS(N), .C_WIDTH(W), .C_SEL_WIDTH(SW), .C_HAS_CE(1)) dut (
    .clk  (clk),
    .sclr (sclr),
    .ce   (ce),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {bus.busy, bus.s, bus.ack};
  endfunction

  function automatic logic [9:0] dat();
    return {bus.q_valid, bus.q_last, bus.q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    sclr = 1'b1; ce = 1'b1;
    bus.req = '0; bus.last = '0; bus.d = '0; bus.q_ready = 1'b1;
    tick(); tick();
    sclr = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] wc;
    logic [9:0] wd;
    sclr = 1'b1; ce = 1'b1;
    bus.req = '0; bus.last = '0; bus.d = '0; bus.q_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      wc = '0; n_cmp++;
      if (ctl() !== wc) begin n_mis++; $display("FAIL reset_ctl got=%b want=%b", ctl(), wc); end
      wd = '0; n_cmp++;
      if (dat() !== wd) begin n_mis++; $display("FAIL reset_dat got=%h want=%h", dat(), wd); end
    end
    sclr = 1'b0; bus.req = 4'hF; bus.last = 4'hF; bus.d = 32'h44332211;
    settle();
    wc = '0; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL reset_idle got=%b want=%b", ctl(), wc); end
    tick(); settle();
    wc = {1'b1, 2'd0, 4'b0001}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL reset_first_grant got=%b want=%b", ctl(), wc); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [6:0] wc;
    logic [9:0] wd;
    int e, prev;
    do_reset();
    bus.req = 4'hF; bus.last = 4'hF; bus.d = 32'h44332211;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      e = k % N;
      settle();
      n_cmp++;
      if ({bus.busy, bus.ack} !== 5'b0) begin n_mis++; $display("FAIL rr_idle%0d got=%b want=0", k, {bus.busy, bus.ack}); end
      if (k > 0) begin
        wd = {1'b1, 1'b1, 8'(8'h11 * (prev + 1))}; n_cmp++;
        if (dat() !== wd) begin n_mis++; $display("FAIL rr_q%0d got=%h want=%h", k, dat(), wd); end
      end
      tick(); settle();
      wc = {1'b1, 2'(e), 4'(4'b0001 << e)}; n_cmp++;
      if (ctl() !== wc) begin n_mis++; $display("FAIL rr_grant%0d got=%b want=%b", k, ctl(), wc); end
      prev = e;
      tick();
    end
    settle();
    wd = {1'b1, 1'b1, 8'h11}; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL rr_q_final got=%h want=%h", dat(), wd); end
  endtask

  task automatic test_packet_lock();
    logic [6:0] wc;
    logic [9:0] wd;
    do_reset();
    bus.req = 4'b1010; bus.last = 4'b0000; bus.d = 32'hAA001100;
    settle(); tick(); settle();
    wc = {1'b1, 2'd1, 4'b0010}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL lock_b1 got=%b want=%b", ctl(), wc); end
    tick();
    bus.d[15:8] = 8'h12; settle();
    n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL lock_b2 got=%b want=%b", ctl(), wc); end
    wd = {1'b1, 1'b0, 8'h11}; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL lock_q1 got=%h want=%h", dat(), wd); end
    tick();
    bus.d[15:8] = 8'h13; bus.last = 4'b1010; settle();
    n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL lock_b3 got=%b want=%b", ctl(), wc); end
    wd = {1'b1, 1'b0, 8'h12}; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL lock_q2 got=%h want=%h", dat(), wd); end
    tick(); settle();
    wc = {1'b0, 2'd1, 4'b0000}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL lock_idle got=%b want=%b", ctl(), wc); end
    wd = {1'b1, 1'b1, 8'h13}; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL lock_q3 got=%h want=%h", dat(), wd); end
    tick(); settle();
    wc = {1'b1, 2'd3, 4'b1000}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL lock_next got=%b want=%b", ctl(), wc); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [6:0] wc;
    logic [9:0] wd;
    do_reset();
    bus.req = 4'b0001; bus.last = 4'b0000; bus.d = 32'h40;
    settle(); tick(); settle();
    wc = {1'b1, 2'd0, 4'b0001}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL bp_first got=%b want=%b", ctl(), wc); end
    tick();
    bus.q_ready = 1'b0; bus.d = 32'h41;
    for (int i = 0; i < 5; i++) begin
      settle();
      wc = {1'b1, 2'd0, 4'b0000}; n_cmp++;
      if (ctl() !== wc) begin n_mis++; $display("FAIL bp_stall%0d got=%b want=%b", i, ctl(), wc); end
      wd = {1'b1, 1'b0, 8'h40}; n_cmp++;
      if (dat() !== wd) begin n_mis++; $display("FAIL bp_hold%0d got=%h want=%h", i, dat(), wd); end
      tick();
    end
    bus.q_ready = 1'b1; settle();
    wc = {1'b1, 2'd0, 4'b0001}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL bp_resume got=%b want=%b", ctl(), wc); end
    tick();
    bus.d = 32'h42; bus.last = 4'b0001; settle();
    wd = {1'b1, 1'b0, 8'h41}; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL bp_q41 got=%h want=%h", dat(), wd); end
    tick(); settle();
    wd = {1'b1, 1'b1, 8'h42}; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL bp_q42 got=%h want=%h", dat(), wd); end
    wc = {1'b0, 2'd0, 4'b0000}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL bp_idle got=%b want=%b", ctl(), wc); end
    bus.req = '0; tick();
  endtask

  task automatic test_req_gap();
    logic [6:0] wc;
    logic [9:0] wd;
    do_reset();
    bus.req = 4'b0100; bus.last = 4'b0000; bus.d = 32'h00500000;
    settle(); tick(); settle();
    wc = {1'b1, 2'd2, 4'b0100}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL gap_first got=%b want=%b", ctl(), wc); end
    tick();
    bus.req = '0;
    for (int i = 0; i < 2; i++) begin
      settle();
      wc = {1'b1, 2'd2, 4'b0000}; n_cmp++;
      if (ctl() !== wc) begin n_mis++; $display("FAIL gap_stall%0d got=%b want=%b", i, ctl(), wc); end
      wd = {(i == 0), 1'b0, 8'h50}; n_cmp++;
      if (dat() !== wd) begin n_mis++; $display("FAIL gap_q%0d got=%h want=%h", i, dat(), wd); end
      tick();
    end
    bus.req = 4'b0100; bus.last = 4'b0100; bus.d = 32'h00510000; settle();
    wc = {1'b1, 2'd2, 4'b0100}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL gap_resume got=%b want=%b", ctl(), wc); end
    tick(); settle();
    wd = {1'b1, 1'b1, 8'h51}; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL gap_done got=%h want=%h", dat(), wd); end
    bus.req = '0; tick();
  endtask

  task automatic test_reset_mid_packet();
    logic [6:0] wc;
    logic [9:0] wd;
    do_reset();
    bus.req = 4'hF; bus.last = 4'h0; bus.d = 32'h44332211;
    settle(); tick(); settle();
    wc = {1'b1, 2'd0, 4'b0001}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL mid_b1 got=%b want=%b", ctl(), wc); end
    tick();
    sclr = 1'b1; settle();
    wc = {1'b1, 2'd0, 4'b0000}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL mid_no_ack got=%b want=%b", ctl(), wc); end
    tick();
    sclr = 1'b0; settle();
    wc = '0; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL mid_idle got=%b want=%b", ctl(), wc); end
    wd = '0; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL mid_q got=%h want=%h", dat(), wd); end
    tick(); settle();
    wc = {1'b1, 2'd0, 4'b0001}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL mid_regrant got=%b want=%b", ctl(), wc); end
    bus.req = '0; tick();
  endtask

  task automatic test_ce();
    logic [6:0] wc;
    logic [9:0] wd;
    do_reset();
    bus.req = 4'b0001; bus.last = 4'b0000; bus.d = 32'h60;
    settle(); tick(); settle(); tick();
    ce = 1'b0; bus.d = 32'h61; bus.last = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      settle();
      wc = {1'b1, 2'd0, 4'b0000}; n_cmp++;
      if (ctl() !== wc) begin n_mis++; $display("FAIL ce_ctl%0d got=%b want=%b", i, ctl(), wc); end
      wd = {1'b1, 1'b0, 8'h60}; n_cmp++;
      if (dat() !== wd) begin n_mis++; $display("FAIL ce_dat%0d got=%h want=%h", i, dat(), wd); end
      tick();
    end
    ce = 1'b1; settle();
    wc = {1'b1, 2'd0, 4'b0001}; n_cmp++;
    if (ctl() !== wc) begin n_mis++; $display("FAIL ce_resume got=%b want=%b", ctl(), wc); end
    tick(); settle();
    wd = {1'b1, 1'b1, 8'h61}; n_cmp++;
    if (dat() !== wd) begin n_mis++; $display("FAIL ce_done got=%h want=%h", dat(), wd); end
    bus.req = '0; tick();
  endtask

  // Reference: owner < 0 means the arbiter is choosing; the output register
  // is a queue holding at most one beat.
  typedef struct packed { logic [W-1:0] data; logic last; } beat_t;

  task automatic test_random();
    beat_t      outq[$];
    int         owner, ptr, s_exp, w;
    logic [W-1:0] qd;
    logic       ql, xf;
    logic [3:0] ack_exp;
    logic [6:0] wc;
    logic [9:0] wd;
    do_reset();
    owner = -1; ptr = N - 1; s_exp = 0; qd = '0; ql = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      sclr        = ($urandom % 100) == 0;
      ce          = ($urandom % 10) != 0;
      bus.req     = 4'($urandom);
      bus.last    = 4'($urandom & $urandom);
      bus.q_ready = ($urandom % 4) != 0;
      bus.d       = $urandom;
      settle();
      xf = !sclr && ce && owner >= 0 && bus.req[owner] && (outq.size() == 0 || bus.q_ready);
      ack_exp = xf ? 4'(4'b0001 << owner) : 4'b0000;
      wc = {owner >= 0, 2'(s_exp), ack_exp}; n_cmp++;
      if (ctl() !== wc) begin n_mis++; $display("FAIL rand_ctl c=%0d got=%b want=%b", c, ctl(), wc); end
      wd = {outq.size() != 0, ql, qd}; n_cmp++;
      if (dat() !== wd) begin n_mis++; $display("FAIL rand_dat c=%0d got=%h want=%h", c, dat(), wd); end
      if (sclr) begin
        owner = -1; ptr = N - 1; s_exp = 0; outq.delete(); qd = '0; ql = 1'b0;
      end else if (ce) begin
        if (xf) begin
          outq.delete();
          qd = bus.d[owner*W +: W]; ql = bus.last[owner];
          outq.push_back('{qd, ql});
        end else if (bus.q_ready) begin
          outq.delete();
        end
        if (owner < 0) begin
          w = -1;
          for (int k = 1; k <= N && w < 0; k++)
            if (bus.req[(ptr + k) % N]) w = (ptr + k) % N;
          if (w >= 0) begin owner = w; s_exp = w; end
        end else if (xf && ql) begin
          ptr = owner; owner = -1;
        end
      end
      tick();
    end
    sclr = 1'b0; ce = 1'b1; bus.req = '0;
  endtask

  initial begin
    sclr = 1'b1; ce = 1'b1;
    bus.req = '0; bus.last = '0; bus.d = '0; bus.q_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_req_gap();
    test_reset_mid_packet();
    test_ce();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
